// File: rtl/packet_framer.sv
// rtl/packet_framer.sv - packet to UART frame serialiser: payload, sentinel, timestamp, optional length
module packet_framer #(
  parameter int         TS_BYTES      = 4,
  parameter int         LEN_BYTES     = 0,
  parameter logic [7:0] SENTINEL      = 8'h00,
  parameter logic [7:0] ESC           = 8'h7D,
  parameter bit         ESCAPE_ENABLE = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            packet_data,
  input  logic                  packet_valid,
  output logic                  packet_ready,
  input  logic                  packet_last,
  input  logic [TS_BYTES*8-1:0] clock_data,
  input  logic                  clock_valid,
  output logic                  clock_ready,
  output logic [7:0]            uart_data,
  output logic                  uart_valid,
  input  logic                  uart_ready,
  output logic                  frame_done
);

  localparam logic [2:0] ST_PACKET   = 3'd0;
  localparam logic [2:0] ST_ESCAPE   = 3'd1;
  localparam logic [2:0] ST_SENTINEL = 3'd2;
  localparam logic [2:0] ST_CLOCK    = 3'd3;
  localparam logic [2:0] ST_LENGTH   = 3'd4;

  // Counter keeps a byte of width even without a length field so the selects stay legal.
  localparam int         LW       = (LEN_BYTES > 0) ? LEN_BYTES * 8 : 8;
  localparam bit         HAS_LEN  = (LEN_BYTES > 0);
  localparam logic [2:0] TS_LAST  = 3'(TS_BYTES - 1);
  localparam logic [2:0] LEN_LAST = 3'((LEN_BYTES > 0) ? LEN_BYTES - 1 : 0);

  logic [2:0]    state;
  logic [2:0]    idx;
  logic [LW-1:0] len;
  logic          special;
  logic          xfer;
  logic          ts_last;
  logic          len_last;
  logic          count_byte;

  always_comb begin
    special      = ESCAPE_ENABLE && ((packet_data == SENTINEL) || (packet_data == ESC));
    ts_last      = (idx == TS_LAST);
    len_last     = (idx == LEN_LAST);
    uart_data    = packet_data;
    uart_valid   = 1'b0;
    packet_ready = 1'b0;
    case (state)
      ST_PACKET: begin
        uart_valid = packet_valid;
        if (special) uart_data = ESC;
        else         packet_ready = uart_ready;
      end
      ST_ESCAPE: begin
        uart_data    = packet_data ^ 8'h20;
        uart_valid   = packet_valid;
        packet_ready = uart_ready;
      end
      ST_SENTINEL: begin
        uart_data  = SENTINEL;
        uart_valid = 1'b1;
      end
      ST_CLOCK: begin
        uart_data  = clock_data[{TS_LAST - idx, 3'b000} +: 8];
        uart_valid = clock_valid;
      end
      ST_LENGTH: begin
        uart_data  = len[{LEN_LAST - idx, 3'b000} +: 8];
        uart_valid = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      uart_valid   = 1'b0;
      packet_ready = 1'b0;
    end
    // Every strobe below derives from xfer, so reset silences them all.
    xfer        = uart_valid && uart_ready;
    clock_ready = xfer && (state == ST_CLOCK) && ts_last;
    frame_done  = xfer && (((state == ST_CLOCK) && ts_last && !HAS_LEN) ||
                           ((state == ST_LENGTH) && len_last));
    count_byte  = xfer && (((state == ST_PACKET) && !special) || (state == ST_ESCAPE));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_PACKET;
      idx   <= 3'd0;
      len   <= '0;
    end else begin
      if (count_byte && (len != '1)) len <= len + LW'(1);
      if (frame_done) len <= '0;
      case (state)
        ST_PACKET: if (xfer) begin
          if (special)          state <= ST_ESCAPE;
          else if (packet_last) state <= ST_SENTINEL;
        end
        ST_ESCAPE: if (xfer) state <= packet_last ? ST_SENTINEL : ST_PACKET;
        ST_SENTINEL: if (xfer) begin
          state <= ST_CLOCK;
          idx   <= 3'd0;
        end
        ST_CLOCK: if (xfer) begin
          if (ts_last) begin
            idx   <= 3'd0;
            state <= HAS_LEN ? ST_LENGTH : ST_PACKET;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        ST_LENGTH: if (xfer) begin
          if (len_last) begin
            idx   <= 3'd0;
            state <= ST_PACKET;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        default: state <= ST_PACKET;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_framer.sv
// tb/tb_packet_framer.sv - directed bench for packet_framer (4-byte ts no length; 8-byte ts 1-byte length)
module tb_packet_framer;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [7:0]  a_packet_data, a_uart_data;
  logic        a_packet_valid, a_packet_ready, a_packet_last;
  logic [31:0] a_clock_data;
  logic        a_clock_valid, a_clock_ready, a_uart_valid, a_uart_ready, a_frame_done;

  logic [7:0]  b_packet_data, b_uart_data;
  logic        b_packet_valid, b_packet_ready, b_packet_last;
  logic [63:0] b_clock_data;
  logic        b_clock_valid, b_clock_ready, b_uart_valid, b_uart_ready, b_frame_done;

  packet_framer #(.TS_BYTES(4), .LEN_BYTES(0), .SENTINEL(8'h00), .ESC(8'h7D), .ESCAPE_ENABLE(1'b1)) dut_a (
    .clock(clock), .reset(reset),
    .packet_data(a_packet_data), .packet_valid(a_packet_valid), .packet_ready(a_packet_ready),
    .packet_last(a_packet_last), .clock_data(a_clock_data), .clock_valid(a_clock_valid),
    .clock_ready(a_clock_ready), .uart_data(a_uart_data), .uart_valid(a_uart_valid),
    .uart_ready(a_uart_ready), .frame_done(a_frame_done));

  packet_framer #(.TS_BYTES(8), .LEN_BYTES(1), .SENTINEL(8'h00), .ESC(8'h7D), .ESCAPE_ENABLE(1'b1)) dut_b (
    .clock(clock), .reset(reset),
    .packet_data(b_packet_data), .packet_valid(b_packet_valid), .packet_ready(b_packet_ready),
    .packet_last(b_packet_last), .clock_data(b_clock_data), .clock_valid(b_clock_valid),
    .clock_ready(b_clock_ready), .uart_data(b_uart_data), .uart_valid(b_uart_valid),
    .uart_ready(b_uart_ready), .frame_done(b_frame_done));

  int checks = 0;
  int errors = 0;
  logic [7:0]  qa[$], qb[$], pr_q[$], ex[$];
  logic [8:0]  pay_q[$];
  logic [8:0]  pay_tmp;
  int          fd_a = 0, fd_b = 0, cr_a = 0;
  logic [7:0]  fd_byte_a;
  bit          a_pay_took, a_ts_took, gaps, ur_toggle, ts_arm;
  int          ts_wait;
  logic [31:0] ts_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cmp_q(input string tag, input logic [7:0] got[$]);
    chk({tag, "_len"}, 64'(got.size()), 64'(ex.size()));
    for (int i = 0; i < ex.size() && i < got.size(); i++)
      chk($sformatf("%s_%0d", tag, i), 64'(got[i]), 64'(ex[i]));
  endtask

  task automatic wait_fd(input bit sel, input int target);
    int n = 0;
    while (((sel ? fd_b : fd_a) < target) && n < 2000) begin
      @(posedge clock); #3;
      n++;
    end
    chk(sel ? "fd_b_timeout" : "fd_a_timeout", 64'((sel ? fd_b : fd_a) >= target), 64'd1);
  endtask

  task automatic b_send(input logic [7:0] d, input logic last);
    bit took = 1'b0;
    int n = 0;
    b_packet_data  = d;
    b_packet_last  = last;
    b_packet_valid = 1'b1;
    while (!took && n < 20) begin
      @(negedge clock);
      took = b_packet_valid && b_packet_ready;
      @(posedge clock); #3;
      n++;
    end
    chk("b_send_accept", 64'(took), 64'd1);
  endtask

  task automatic b_frame(input logic [63:0] ts, input int target);
    b_packet_valid = 1'b0;
    b_clock_data   = ts;
    b_clock_valid  = 1'b1;
    wait_fd(1'b1, target);
    b_clock_valid  = 1'b0;
  endtask

  // Bus observation half a cycle away from the active edge.
  always @(negedge clock) begin
    a_pay_took = a_packet_valid && a_packet_ready;
    a_ts_took  = a_clock_valid && a_clock_ready;
    if (a_uart_valid && a_uart_ready) qa.push_back(a_uart_data);
    if (a_pay_took) pr_q.push_back(a_uart_data);
    if (a_frame_done) begin
      fd_a++;
      fd_byte_a = a_uart_data;
    end
    if (a_clock_ready) cr_a++;
    if (b_uart_valid && b_uart_ready) qb.push_back(b_uart_data);
    if (b_frame_done) fd_b++;
  end

  // Payload/timestamp sources and UART sink for instance A.
  always @(posedge clock) begin
    #1;
    if (a_pay_took) pay_tmp = pay_q.pop_front();
    if (a_packet_valid && !a_pay_took) begin
    end else if (pay_q.size() > 0 && (!gaps || $urandom_range(0, 1) == 1)) begin
      a_packet_valid = 1'b1;
      a_packet_data  = pay_q[0][7:0];
      a_packet_last  = pay_q[0][8];
    end else begin
      a_packet_valid = 1'b0;
    end
    a_uart_ready = ur_toggle ? !a_uart_ready : 1'b1;
    if (a_ts_took) begin
      a_clock_valid = 1'b0;
      ts_arm = 1'b0;
    end else if (ts_arm && pay_q.size() == 0) begin
      if (ts_wait > 0) ts_wait--;
      else begin
        a_clock_valid = 1'b1;
        a_clock_data  = ts_data;
      end
    end
  end

  initial begin
    reset = 1'b1;
    a_packet_valid = 1'b1; a_packet_data = 8'h55; a_packet_last = 1'b1;
    a_clock_valid = 1'b1; a_clock_data = 32'h0; a_uart_ready = 1'b1;
    b_packet_valid = 1'b1; b_packet_data = 8'h33; b_packet_last = 1'b0;
    b_clock_valid = 1'b1; b_clock_data = 64'h0; b_uart_ready = 1'b1;
    gaps = 1'b0; ur_toggle = 1'b0; ts_arm = 1'b0; ts_wait = 0; ts_data = 32'h0;
    repeat (3) @(posedge clock);
    #3;
    chk("rst_a_uart_valid", 64'(a_uart_valid), 64'd0);
    chk("rst_a_packet_ready", 64'(a_packet_ready), 64'd0);
    chk("rst_a_clock_ready", 64'(a_clock_ready), 64'd0);
    chk("rst_a_frame_done", 64'(a_frame_done), 64'd0);
    chk("rst_b_uart_valid", 64'(b_uart_valid), 64'd0);
    chk("rst_b_packet_ready", 64'(b_packet_ready), 64'd0);
    a_packet_valid = 1'b0; a_clock_valid = 1'b0; a_packet_last = 1'b0;
    b_packet_valid = 1'b0; b_clock_valid = 1'b0;
    @(posedge clock); #3;
    reset = 1'b0;
    qa.delete(); qb.delete(); pr_q.delete();

    // Plain two-byte payload.
    pay_q = {9'h011, 9'h122};
    ts_data = 32'hA1B2C3D4; ts_wait = 0; ts_arm = 1'b1;
    wait_fd(1'b0, 1);
    ex = {8'h11, 8'h22, 8'h00, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
    cmp_q("c1", qa);
    chk("c1_clock_ready_cnt", 64'(cr_a), 64'd1);
    chk("c1_frame_done_cnt", 64'(fd_a), 64'd1);
    chk("c1_frame_done_byte", 64'(fd_byte_a), 64'hD4);
    qa.delete(); pr_q.delete();

    // Stuffed payload.
    pay_q = {9'h000, 9'h07D, 9'h105};
    ts_data = 32'h01020304; ts_arm = 1'b1;
    wait_fd(1'b0, 2);
    ex = {8'h7D, 8'h20, 8'h7D, 8'h5D, 8'h05, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    cmp_q("c2", qa);
    ex = {8'h20, 8'h5D, 8'h05};
    cmp_q("c2_packet_ready", pr_q);
    qa.delete(); pr_q.delete();

    // Backpressure, source gaps and a late timestamp.
    gaps = 1'b1; ur_toggle = 1'b1;
    pay_q = {9'h011, 9'h122};
    ts_data = 32'hA1B2C3D4; ts_wait = 5; ts_arm = 1'b1;
    wait_fd(1'b0, 3);
    ex = {8'h11, 8'h22, 8'h00, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
    cmp_q("c4", qa);
    chk("c4_clock_ready_cnt", 64'(cr_a), 64'd3);
    gaps = 1'b0; ur_toggle = 1'b0;
    repeat (2) @(posedge clock);
    #3;
    qa.delete(); pr_q.delete();

    // Reset after the second timestamp byte, then a one-byte frame.
    pay_q = {9'h011, 9'h122};
    ts_data = 32'hA1B2C3D4; ts_wait = 0; ts_arm = 1'b1;
    for (int n = 0; n < 200 && qa.size() < 5; n++) begin
      @(posedge clock); #3;
    end
    chk("c5_pre_abort_bytes", 64'(qa.size()), 64'd5);
    reset = 1'b1;
    pay_q.delete(); ts_arm = 1'b0;
    a_packet_valid = 1'b0; a_clock_valid = 1'b0;
    repeat (2) @(posedge clock);
    #3;
    reset = 1'b0;
    chk("c5_no_partial_done", 64'(fd_a), 64'd3);
    qa.delete();
    pay_q = {9'h1AA};
    ts_data = 32'h00000001; ts_arm = 1'b1;
    wait_fd(1'b0, 4);
    ex = {8'hAA, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
    cmp_q("c5", qa);
    chk("c5_clock_ready_cnt", 64'(cr_a), 64'd4);

    // Length field counts pre-stuffing bytes and clears per frame.
    b_send(8'h7D, 1'b0); b_send(8'h01, 1'b0); b_send(8'h02, 1'b1);
    b_frame(64'h1122334455667788, 1);
    ex = {8'h7D, 8'h5D, 8'h01, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
          8'h55, 8'h66, 8'h77, 8'h88, 8'h03};
    cmp_q("c3", qb);
    qb.delete();
    b_send(8'h09, 1'b1);
    b_frame(64'h0, 2);
    ex = {8'h09, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
    cmp_q("c3_len_cleared", qb);
    qb.delete();

    // Saturating length with a 300-byte payload.
    for (int i = 0; i < 300; i++) b_send(8'((i % 64) + 1), i == 299);
    b_frame(64'h0102030405060708, 3);
    ex.delete();
    for (int i = 0; i < 300; i++) ex.push_back(8'((i % 64) + 1));
    ex.push_back(8'h00);
    for (int i = 1; i <= 8; i++) ex.push_back(8'(i));
    ex.push_back(8'hFF);
    cmp_q("c6", qb);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
